// File: rtl/ddr3_cmd_burst_gen.sv
// DDR3 command front end: per-bank open-row table and RD/WR burst expansion
// into beat addresses for a single-clock dual-port model RAM.
module ddr3_cmd_burst_gen #(
  parameter int DATA_WIDTH = 8,
  parameter int ADDR_WIDTH = 36,
  parameter int BL         = 8,
  parameter int WL         = 5,
  parameter int RL         = 6
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  cmd_valid_i,
  output logic                  cmd_ready_o,
  input  logic [2:0]            cmd_i,
  input  logic [2:0]            cmd_bank_i,
  input  logic [15:0]           cmd_addr_i,
  output logic                  wdata_req_o,
  input  logic [DATA_WIDTH-1:0] wdata_i,
  output logic                  ram_we_o,
  output logic [ADDR_WIDTH-1:0] ram_waddr_o,
  output logic [DATA_WIDTH-1:0] ram_di_o,
  output logic [ADDR_WIDTH-1:0] ram_raddr_o,
  input  logic [DATA_WIDTH-1:0] ram_dout_i,
  output logic [DATA_WIDTH-1:0] rdata_o,
  output logic                  rdata_valid_o,
  output logic                  cmd_err_o
);
  localparam int CW = 8;
  localparam logic [2:0] C_ACT = 3'd1, C_RD = 3'd2, C_WR = 3'd3, C_PRE = 3'd4;
  localparam logic [CW-1:0] WR_FIRST = CW'(WL - 1);
  localparam logic [CW-1:0] WR_LAST  = CW'(WL + BL - 2);
  localparam logic [CW-1:0] WR_END   = CW'(WL + BL - 1);
  localparam logic [CW-1:0] RD_FIRST = CW'(RL - 1);
  localparam logic [CW-1:0] RD_LAST  = CW'(RL + BL - 2);
  localparam logic [CW-1:0] RD_END   = CW'(RL + BL - 1);
  localparam logic [15:0]   BMASK    = 16'(BL - 1);

  typedef enum logic [1:0] {IDLE, LAT, BURST} state_e;

  state_e                  state_q, state_d;
  logic [CW-1:0]           cnt_q, cnt_d;
  logic                    is_wr_q, is_wr_d;
  logic [2:0]              bank_q, bank_d;
  logic [15:0]             row_q, row_d, col_q, col_d;
  logic [7:0]              open_q, open_d;
  logic [7:0][15:0]        rowtab_q, rowtab_d;
  logic                    err_q, err_d;
  logic                    we_q, rv_q;
  logic [ADDR_WIDTH-1:0]   waddr_q, raddr_q;
  logic [DATA_WIDTH-1:0]   di_q;

  logic                    busy, wr_win, rd_win, accept;
  logic [CW-1:0]           beat;
  logic [15:0]             beat_col;
  logic [ADDR_WIDTH-1:0]   beat_addr;

  // cnt_q equals the cycle number relative to the accept cycle while busy
  assign busy      = (state_q != IDLE);
  assign wr_win    = busy &  is_wr_q & (cnt_q >= WR_FIRST) & (cnt_q <= WR_LAST);
  assign rd_win    = busy & ~is_wr_q & (cnt_q >= RD_FIRST) & (cnt_q <= RD_LAST);
  assign beat      = is_wr_q ? (cnt_q - WR_FIRST) : (cnt_q - RD_FIRST);
  assign beat_col  = (col_q & ~BMASK) | ((col_q + 16'(beat)) & BMASK);
  assign beat_addr = ADDR_WIDTH'({1'b0, bank_q, row_q, beat_col});
  assign accept    = cmd_valid_i & cmd_ready_o;

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    is_wr_d  = is_wr_q;
    bank_d   = bank_q;
    row_d    = row_q;
    col_d    = col_q;
    open_d   = open_q;
    rowtab_d = rowtab_q;
    err_d    = 1'b0;
    case (state_q)
      IDLE: begin
        if (accept) begin
          case (cmd_i)
            C_ACT: begin
              err_d                = open_q[cmd_bank_i];
              open_d[cmd_bank_i]   = 1'b1;
              rowtab_d[cmd_bank_i] = cmd_addr_i;
            end
            C_PRE: begin
              if (cmd_addr_i[10]) open_d = '0;
              else                open_d[cmd_bank_i] = 1'b0;
            end
            C_RD, C_WR: begin
              if (!open_q[cmd_bank_i]) begin
                err_d = 1'b1;
              end else begin
                bank_d  = cmd_bank_i;
                row_d   = rowtab_q[cmd_bank_i];
                col_d   = cmd_addr_i;
                is_wr_d = (cmd_i == C_WR);
                cnt_d   = CW'(1);
                state_d = LAT;
              end
            end
            default: ;
          endcase
        end
      end
      LAT: begin
        cnt_d = cnt_q + CW'(1);
        if ((cnt_q + CW'(1)) >= (is_wr_q ? WR_FIRST : RD_FIRST)) state_d = BURST;
      end
      BURST: begin
        cnt_d = cnt_q + CW'(1);
        if (cnt_q == (is_wr_q ? WR_END : RD_END)) begin
          state_d = IDLE;
          cnt_d   = '0;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      cnt_q    <= '0;
      is_wr_q  <= 1'b0;
      bank_q   <= '0;
      row_q    <= '0;
      col_q    <= '0;
      open_q   <= '0;
      rowtab_q <= '0;
      err_q    <= 1'b0;
      we_q     <= 1'b0;
      rv_q     <= 1'b0;
      waddr_q  <= '0;
      raddr_q  <= '0;
      di_q     <= '0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      is_wr_q  <= is_wr_d;
      bank_q   <= bank_d;
      row_q    <= row_d;
      col_q    <= col_d;
      open_q   <= open_d;
      rowtab_q <= rowtab_d;
      err_q    <= err_d;
      we_q     <= wr_win;
      rv_q     <= rd_win;
      if (wr_win) begin
        waddr_q <= beat_addr;
        di_q    <= wdata_i;
      end
      if (rd_win) raddr_q <= beat_addr;
    end
  end

  // read address is presented combinationally so the registered RAM returns data one cycle later
  assign ram_raddr_o   = rd_win ? beat_addr : raddr_q;
  assign cmd_ready_o   = rst_n & ~busy;
  assign wdata_req_o   = wr_win;
  assign ram_we_o      = we_q;
  assign ram_waddr_o   = waddr_q;
  assign ram_di_o      = di_q;
  assign rdata_o       = ram_dout_i;
  assign rdata_valid_o = rv_q;
  assign cmd_err_o     = err_q;
endmodule

// File: tb/tb_ddr3_cmd_burst_gen.sv
// Bench for ddr3_cmd_burst_gen: cycle timeline reference model, a model RAM,
// a table of single-cycle commands, directed burst/reset sequences and random traffic.
module tb_ddr3_cmd_burst_gen;
  localparam int DW = 8, AW = 36, BL = 8, WL = 5, RL = 6;
  localparam int MAXC = 4096;

  logic          clk = 1'b0, rst_n = 1'b0;
  logic          cmd_valid = 1'b0, cmd_ready;
  logic [2:0]    cmd = '0, cmd_bank = '0;
  logic [15:0]   cmd_addr = '0;
  logic          wdata_req, ram_we, rdata_valid, cmd_err;
  logic [DW-1:0] wdata = '0, ram_di, ram_dout = '0, rdata;
  logic [AW-1:0] ram_waddr, ram_raddr;

  ddr3_cmd_burst_gen #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .BL(BL), .WL(WL), .RL(RL)) dut (
    .clk(clk), .rst_n(rst_n), .cmd_valid_i(cmd_valid), .cmd_ready_o(cmd_ready),
    .cmd_i(cmd), .cmd_bank_i(cmd_bank), .cmd_addr_i(cmd_addr),
    .wdata_req_o(wdata_req), .wdata_i(wdata), .ram_we_o(ram_we), .ram_waddr_o(ram_waddr),
    .ram_di_o(ram_di), .ram_raddr_o(ram_raddr), .ram_dout_i(ram_dout), .rdata_o(rdata),
    .rdata_valid_o(rdata_valid), .cmd_err_o(cmd_err));

  always #5 clk = ~clk;

  // model RAM folded onto a 13-bit index {bank,row[3:0],col[5:0]}
  bit [7:0] tb_mem [8192];
  always @(posedge clk) begin
    if (ram_we) tb_mem[{ram_waddr[34:32], ram_waddr[19:16], ram_waddr[5:0]}] <= ram_di;
    ram_dout <= tb_mem[{ram_raddr[34:32], ram_raddr[19:16], ram_raddr[5:0]}];
  end

  int nvec = 0, nerr = 0, cyc = 0, busy_end = -1;
  bit          e_req[MAXC], e_we[MAXC], e_rv[MAXC], e_err[MAXC], e_rav[MAXC];
  logic [35:0] e_wa[MAXC], e_ra[MAXC], e_rva[MAXC];
  logic [7:0]  e_di[MAXC];
  bit          m_open[8];
  logic [15:0] m_row[8];
  bit [7:0]    ref_mem[8192];

  function automatic logic [12:0] idx(input logic [35:0] a);
    return {a[34:32], a[19:16], a[5:0]};
  endfunction

  // beat b of a burst wraps inside the BL-aligned column block
  function automatic logic [35:0] baddr(input logic [2:0] bk, input logic [15:0] row,
                                        input logic [15:0] col, input int b);
    int c0, c2;
    c0 = int'(col);
    c2 = (c0 - c0 % BL) + ((c0 % BL + b) % BL);
    return {1'b0, bk, row, c2[15:0]};
  endfunction

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    nvec++;
    if (act !== exp) begin
      nerr++;
      $display("FAIL %s cyc=%0d got=%h want=%h", nm, cyc, act, exp);
    end
  endtask

  task automatic clear_model();
    for (int i = 0; i < MAXC; i++) begin
      e_req[i] = 0; e_we[i] = 0; e_rv[i] = 0; e_err[i] = 0; e_rav[i] = 0;
    end
    for (int i = 0; i < 8; i++) m_open[i] = 0;
    busy_end = -1;
  endtask

  task automatic model_issue(input logic [2:0] c, input logic [2:0] b, input logic [15:0] a);
    if (cyc <= busy_end) return;
    case (c)
      3'd1: begin
        if (m_open[b]) e_err[cyc+1] = 1;
        m_open[b] = 1; m_row[b] = a;
      end
      3'd4: begin
        if (a[10]) for (int i = 0; i < 8; i++) m_open[i] = 0;
        else m_open[b] = 0;
      end
      3'd2, 3'd3: begin
        if (!m_open[b]) e_err[cyc+1] = 1;
        else begin
          for (int bt = 0; bt < BL; bt++) begin
            if (c == 3'd3) begin
              e_req[cyc+WL-1+bt] = 1;
              e_we[cyc+WL+bt]    = 1;
              e_wa[cyc+WL+bt]    = baddr(b, m_row[b], a, bt);
            end else begin
              e_rav[cyc+RL-1+bt] = 1;
              e_ra[cyc+RL-1+bt]  = baddr(b, m_row[b], a, bt);
              e_rv[cyc+RL+bt]    = 1;
              e_rva[cyc+RL+bt]   = baddr(b, m_row[b], a, bt);
            end
          end
          busy_end = cyc + ((c == 3'd3) ? WL : RL) + BL - 1;
        end
      end
      default: ;
    endcase
  endtask

  task automatic check_cycle();
    chk("cmd_ready", 64'(cmd_ready), 64'(cyc > busy_end));
    chk("wdata_req", 64'(wdata_req), 64'(e_req[cyc]));
    chk("ram_we", 64'(ram_we), 64'(e_we[cyc]));
    if (e_we[cyc]) begin
      chk("ram_waddr", 64'(ram_waddr), 64'(e_wa[cyc]));
      chk("ram_di", 64'(ram_di), 64'(e_di[cyc]));
    end
    if (e_rav[cyc]) chk("ram_raddr", 64'(ram_raddr), 64'(e_ra[cyc]));
    chk("rdata_valid", 64'(rdata_valid), 64'(e_rv[cyc]));
    if (e_rv[cyc]) chk("rdata", 64'(rdata), 64'(ref_mem[idx(e_rva[cyc])]));
    chk("cmd_err", 64'(cmd_err), 64'(e_err[cyc]));
  endtask

  // one cycle: check current outputs, drive this cycle's inputs, advance to next negedge
  task automatic tick(input bit v, input logic [2:0] c, input logic [2:0] b,
                      input logic [15:0] a, input logic [7:0] wd);
    check_cycle();
    cmd_valid = v; cmd = c; cmd_bank = b; cmd_addr = a; wdata = wd;
    if (e_req[cyc]) e_di[cyc+1] = wd;
    if (v) model_issue(c, b, a);
    @(negedge clk);
    if (e_we[cyc]) ref_mem[idx(e_wa[cyc])] = e_di[cyc];
    cyc++;
  endtask

  task automatic chk_all_zero(input string nm);
    chk({nm, "_ready"}, 64'(cmd_ready), 0);
    chk({nm, "_wreq"},  64'(wdata_req), 0);
    chk({nm, "_we"},    64'(ram_we), 0);
    chk({nm, "_rv"},    64'(rdata_valid), 0);
    chk({nm, "_err"},   64'(cmd_err), 0);
    chk({nm, "_waddr"}, 64'(ram_waddr), 0);
    chk({nm, "_raddr"}, 64'(ram_raddr), 0);
    chk({nm, "_di"},    64'(ram_di), 0);
  endtask

  typedef struct {
    logic [2:0]  cmd;
    logic [2:0]  bank;
    logic [15:0] addr;
    bit          err;
  } vec_t;

  initial begin
    vec_t tbl[15];
    int   k, off, exp_cols[8];
    int   wcyc[$], rcyc[$];
    logic [15:0] wcol[$];
    logic [7:0]  rdat[$];
    logic [7:0]  wd;
    logic [2:0]  c;
    int   r;

    tbl = '{'{3'd1, 3'd1, 16'h0005, 1'b0}, '{3'd1, 3'd1, 16'h0006, 1'b1},
            '{3'd4, 3'd0, 16'h0400, 1'b0}, '{3'd3, 3'd1, 16'h0000, 1'b1},
            '{3'd2, 3'd4, 16'h0010, 1'b1}, '{3'd1, 3'd4, 16'h0777, 1'b0},
            '{3'd4, 3'd4, 16'h0000, 1'b0}, '{3'd2, 3'd4, 16'h0000, 1'b1},
            '{3'd5, 3'd3, 16'h0000, 1'b0}, '{3'd0, 3'd3, 16'h0000, 1'b0},
            '{3'd1, 3'd3, 16'h0001, 1'b0}, '{3'd1, 3'd5, 16'h0002, 1'b0},
            '{3'd4, 3'd3, 16'h0000, 1'b0}, '{3'd1, 3'd5, 16'h0003, 1'b1},
            '{3'd4, 3'd0, 16'h0400, 1'b0}};
    exp_cols = '{5, 6, 7, 0, 1, 2, 3, 4};
    clear_model();

    #2 chk_all_zero("rst");
    @(negedge clk); @(negedge clk);
    rst_n = 1'b1;
    #1 chk("rst_release_ready", 64'(cmd_ready), 1);

    foreach (tbl[i]) begin
      tick(1, tbl[i].cmd, tbl[i].bank, tbl[i].addr, 8'h00);
      chk("tbl_err", 64'(cmd_err), 64'(tbl[i].err));
      chk("tbl_ready", 64'(cmd_ready), 1);
    end
    tick(0, 0, 0, 0, 0);

    // write burst with wrap, then read it back
    tick(1, 3'd1, 3'd2, 16'h0123, 0);
    k = cyc;
    tick(1, 3'd3, 3'd2, 16'h0005, 0);
    for (int i = 0; i < 16; i++) begin
      off = cyc - k;
      if (ram_we) begin
        wcyc.push_back(off);
        wcol.push_back(ram_waddr[15:0]);
        chk("wr_bank_row", 64'(ram_waddr[35:16]), 64'({1'b0, 3'd2, 16'h0123}));
      end
      wd = (off >= WL-1 && off <= WL+BL-2) ? 8'(8'hA0 + off - (WL-1)) : 8'h00;
      tick(0, 0, 0, 0, wd);
    end
    chk("wr_beat_count", 64'(wcyc.size()), 8);
    for (int j = 0; j < 8 && j < wcyc.size(); j++) begin
      chk("wr_cycle", 64'(wcyc[j]), 64'(5 + j));
      chk("wr_col", 64'(wcol[j]), 64'(exp_cols[j]));
    end

    k = cyc;
    tick(1, 3'd2, 3'd2, 16'h0005, 0);
    for (int i = 0; i < 16; i++) begin
      off = cyc - k;
      if (rdata_valid) begin
        rcyc.push_back(off);
        rdat.push_back(rdata);
      end
      tick(0, 0, 0, 0, 0);
    end
    chk("rd_beat_count", 64'(rcyc.size()), 8);
    for (int j = 0; j < 8 && j < rcyc.size(); j++) begin
      chk("rd_cycle", 64'(rcyc[j]), 64'(6 + j));
      chk("rd_data", 64'(rdat[j]), 64'(8'hA0 + j));
    end

    // reset during write beat 3
    k = cyc;
    tick(1, 3'd3, 3'd2, 16'h0010, 0);
    while (cyc - k != WL + 3) tick(0, 0, 0, 0, 8'($urandom));
    chk("abort_we_before", 64'(ram_we), 1);
    rst_n = 1'b0;
    #1 chk_all_zero("abort");
    @(negedge clk);
    cyc++;
    clear_model();
    rst_n = 1'b1;
    #1;
    tick(1, 3'd2, 3'd2, 16'h0010, 0);
    chk("abort_rd_closed_err", 64'(cmd_err), 1);
    for (int i = 0; i < 4; i++) tick(0, 0, 0, 0, 0);

    // random traffic against the timeline model
    for (int i = 0; i < 2000; i++) begin
      r = $urandom_range(0, 9);
      c = (r < 3) ? 3'd1 : (r < 5) ? 3'd2 : (r < 7) ? 3'd3 : (r < 8) ? 3'd4 :
          (r < 9) ? 3'd0 : 3'($urandom_range(5, 7));
      tick($urandom_range(0, 3) != 0, c, 3'($urandom_range(0, 3)),
           (c == 3'd1) ? 16'($urandom_range(0, 15)) :
           (c == 3'd4) ? (($urandom_range(0, 3) == 0) ? 16'h0400 : 16'h0000) :
           16'($urandom_range(0, 63)), 8'($urandom));
    end
    for (int i = 0; i < 20; i++) tick(0, 0, 0, 0, 0);

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog cyc=%0d got=running want=finished", cyc);
    $fatal(1, "watchdog");
  end
endmodule
